// File: rtl/mem_if_pkg.sv
// ---------------------------------------------------------------------------
// mem_if_pkg
//   Definitions shared by the CPU data-memory interface and its responder.
//   - state_e      : responder FSM state encoding
//   - MEM_ADDR_W   : default request address width shared with the CPU
//   - MEM_DATA_W   : default data width shared with the CPU
//   - cnt_width()  : width of the wait-state counter for a given wait count
// ---------------------------------------------------------------------------
package mem_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned MEM_ADDR_W = 8;
  localparam int unsigned MEM_DATA_W = 8;

  // A counter that has to hold WAIT_CYCLES needs clog2(WAIT_CYCLES+1) bits;
  // keep at least one bit so WAIT_CYCLES=0 still yields a legal vector.
  function automatic int cnt_width(input int wait_cycles);
    int w;
    w = $clog2(wait_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
//   Request/response bundle between the CPU memory-access stage (master)
//   and the data-memory responder (slave).
//   Request : req_valid, req_ready, req_we, req_addr, req_wdata
//   Response: rsp_valid, rsp_ready, rsp_rdata, rsp_err
// ---------------------------------------------------------------------------
interface data_mem_responder_if #(
  parameter int ADDR_W = mem_if_pkg::MEM_ADDR_W,
  parameter int DATA_W = mem_if_pkg::MEM_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_mem_array.sv
// ---------------------------------------------------------------------------
// data_mem_array
//   DEPTH x DATA_W byte store. Synchronous write, combinational read,
//   contents are not reset.
//   clk      in  clock
//   we_i     in  write enable (write happens on the rising edge)
//   addr_i   in  shared read/write address
//   wdata_i  in  write data
//   rdata_o  out read data for addr_i (combinational)
// ---------------------------------------------------------------------------
module data_mem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Target end of the CPU data-memory interface. Accepts one load/store at a
//   time, inserts WAIT_CYCLES wait states, then commits the store or returns
//   the load byte on the response channel. Out-of-range addresses
//   (addr >= DEPTH) suppress the store and answer with rsp_err=1, rdata 0.
//   clk    in  clock, all state on the rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave side of data_mem_responder_if (request + response channels)
// ---------------------------------------------------------------------------
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int CNT_W = cnt_width(WAIT_CYCLES);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0]  WAIT_LD   = CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W:0]   DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept;
  logic              commit;
  logic              eff_we;
  logic [ADDR_W-1:0] eff_addr;
  logic [DATA_W-1:0] eff_wdata;
  logic              in_range;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign accept = (state_q == ST_IDLE) && bus.req_valid;
  // The commit happens on the edge that enters RESP.
  assign commit = (state_q != ST_RESP) && (state_d == ST_RESP);

  // With zero wait states the commit edge is also the accept edge, so the
  // live request must be used; in every later state the latched copy is.
  always_comb begin
    if (state_q == ST_IDLE) begin
      eff_we    = bus.req_we;
      eff_addr  = bus.req_addr;
      eff_wdata = bus.req_wdata;
    end else begin
      eff_we    = we_q;
      eff_addr  = addr_q;
      eff_wdata = wdata_q;
    end
  end

  // Full-width unsigned compare; the extra bit lets DEPTH == 2**ADDR_W fit.
  assign in_range = ({1'b0, eff_addr} < DEPTH_CMP);
  assign mem_we   = commit && eff_we && in_range;

  data_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (eff_addr[AW-1:0]),
    .wdata_i (eff_wdata),
    .rdata_o (mem_rdata)
  );

  // State register plus counter, request latches and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latches, wait counter and response data.
  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      we_d    = bus.req_we;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
      cnt_d   = WAIT_LD;
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (commit) begin
      err_d   = !in_range;
      rdata_d = (eff_we || !in_range) ? '0 : mem_rdata;
    end
  end

  // Outputs.
  always_comb begin
    bus.req_ready = (state_q == ST_IDLE);
    bus.rsp_valid = (state_q == ST_RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//   Two responders share clock and reset: dut_a (DEPTH=128, WAIT_CYCLES=2)
//   and dut_b (DEPTH=256, WAIT_CYCLES=0). 'sel' steers the request signals
//   to one of them and picks which one's outputs are observed.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       req_valid;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_ready;

  logic       obs_req_ready;
  logic       obs_rsp_valid;
  logic [7:0] obs_rsp_rdata;
  logic       obs_rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one byte array per DUT, plus "written" flags since the
  // storage has no reset value.
  logic [7:0] mem_m   [2][256];
  bit         known_m [2][256];

  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) if_a ();
  data_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) if_b ();

  assign if_a.req_valid = req_valid & ~sel;
  assign if_b.req_valid = req_valid &  sel;
  assign if_a.rsp_ready = rsp_ready & ~sel;
  assign if_b.rsp_ready = rsp_ready &  sel;
  assign if_a.req_we    = req_we;
  assign if_b.req_we    = req_we;
  assign if_a.req_addr  = req_addr;
  assign if_b.req_addr  = req_addr;
  assign if_a.req_wdata = req_wdata;
  assign if_b.req_wdata = req_wdata;

  assign obs_req_ready = sel ? if_b.req_ready : if_a.req_ready;
  assign obs_rsp_valid = sel ? if_b.rsp_valid : if_a.rsp_valid;
  assign obs_rsp_rdata = sel ? if_b.rsp_rdata : if_a.rsp_rdata;
  assign obs_rsp_err   = sel ? if_b.rsp_err   : if_a.rsp_err;

  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_CYCLES(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int depth_of(input logic s);
    return s ? 256 : 128;
  endfunction

  function automatic int wait_of(input logic s);
    return s ? 0 : 2;
  endfunction

  // One full transaction. Called at a negedge with the selected DUT idle.
  // hold = number of cycles rsp_ready stays low once the response is up.
  task automatic txn(input logic s, input logic we, input logic [7:0] addr,
                     input logic [7:0] wd, input int hold);
    int         edges;
    bit         err_e;
    logic [7:0] rd_e;
    bit         chk_rd;
    logic [7:0] rd_seen;
    sel = s;
    #1;
    check("idle_req_ready", 32'(obs_req_ready), 32'd1);
    err_e  = (int'(addr) >= depth_of(s));
    rd_e   = (we || err_e) ? 8'h00 : mem_m[s][addr];
    chk_rd = we || err_e || known_m[s][addr];
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    // Scramble request inputs: only the latched copy may matter now.
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 8'($urandom);
    req_wdata = 8'($urandom);
    edges = 1;
    while (!obs_rsp_valid && edges < 40) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check("latency_edges", 32'(edges), 32'(wait_of(s) + 1));
    check("rsp_err", 32'(obs_rsp_err), 32'(err_e));
    if (chk_rd) check("rsp_rdata", 32'(obs_rsp_rdata), 32'(rd_e));
    rd_seen = obs_rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom);
      req_we    = 1'($urandom);
      req_addr  = 8'($urandom);
      req_wdata = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_rsp_valid", 32'(obs_rsp_valid), 32'd1);
      check("hold_rsp_rdata", 32'(obs_rsp_rdata), 32'(rd_seen));
      check("hold_req_ready", 32'(obs_req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(obs_rsp_valid), 32'd0);
    check("post_req_ready", 32'(obs_req_ready), 32'd1);
    if (we && !err_e) begin
      mem_m[s][addr]   = wd;
      known_m[s][addr] = 1'b1;
    end
    $display("txn dut=%0d we=%0d addr=0x%02h wdata=0x%02h hold=%0d -> rdata=0x%02h err=%0d lat=%0d",
             s, we, addr, wd, hold, rd_seen, err_e, edges);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pool [8];
    logic [7:0] a;
    logic [7:0] d;
    int         stray;

    for (int i = 0; i < 256; i++) begin
      known_m[0][i] = 1'b0;
      known_m[1][i] = 1'b0;
    end
    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 8'h00; req_wdata = 8'h00; rsp_ready = 1'b0;

    // Reset state of both DUTs.
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check("rst_req_ready", 32'(obs_req_ready), 32'd1);
      check("rst_rsp_valid", 32'(obs_rsp_valid), 32'd0);
      check("rst_rsp_rdata", 32'(obs_rsp_rdata), 32'd0);
      check("rst_rsp_err",   32'(obs_rsp_err),   32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Store then load, WAIT=2.
    txn(1'b0, 1'b1, 8'h10, 8'hA5, 0);
    txn(1'b0, 1'b0, 8'h10, 8'h00, 0);

    // Response held off for 5 cycles.
    txn(1'b0, 1'b0, 8'h10, 8'h00, 5);

    // DEPTH=128 boundary.
    txn(1'b0, 1'b1, 8'h00, 8'h5A, 0);
    txn(1'b0, 1'b1, 8'h80, 8'h3C, 1);
    txn(1'b0, 1'b0, 8'h80, 8'h00, 0);
    txn(1'b0, 1'b0, 8'h00, 8'h00, 0);
    txn(1'b0, 1'b1, 8'h7F, 8'hC3, 0);
    txn(1'b0, 1'b0, 8'h7F, 8'h00, 0);

    // Async reset while a load response with non-zero data is pending.
    sel = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_rsp_valid", 32'(obs_rsp_valid), 32'd1);
    check("pre_rst_rsp_rdata", 32'(obs_rsp_rdata), 32'hA5);
    #2 rst_n = 1'b0;
    #1;
    check("async_req_ready", 32'(obs_req_ready), 32'd1);
    check("async_rsp_valid", 32'(obs_rsp_valid), 32'd0);
    check("async_rsp_rdata", 32'(obs_rsp_rdata), 32'd0);
    check("async_rsp_err",   32'(obs_rsp_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Store aborted by reset while BUSY.
    txn(1'b0, 1'b1, 8'h20, 8'h11, 0);
    sel = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("abort_rsp_valid", 32'(obs_rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (obs_rsp_valid) stray++;
    end
    check("abort_stray_rsp", 32'(stray), 32'd0);
    txn(1'b0, 1'b0, 8'h20, 8'h00, 0);

    // WAIT=0 back-to-back: request held valid, accepts every 2nd cycle.
    sel = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bit         we_k;
      logic [7:0] exp_rd;
      we_k = (k % 2 == 0);
      if (we_k) begin
        a = (k == 2) ? 8'hFF : 8'($urandom);
        d = 8'($urandom);
      end
      #1 check("b2b_req_ready", 32'(obs_req_ready), 32'd1);
      req_valid = 1'b1; req_we = we_k; req_addr = a; req_wdata = d;
      exp_rd = we_k ? 8'h00 : mem_m[1][a];
      @(posedge clk);
      @(negedge clk);
      check("b2b_rsp_valid", 32'(obs_rsp_valid), 32'd1);
      check("b2b_req_ready_busy", 32'(obs_req_ready), 32'd0);
      check("b2b_rsp_err", 32'(obs_rsp_err), 32'd0);
      check("b2b_rsp_rdata", 32'(obs_rsp_rdata), 32'(exp_rd));
      if (we_k) begin
        mem_m[1][a]   = d;
        known_m[1][a] = 1'b1;
      end
      $display("txn dut=1 b2b we=%0d addr=0x%02h wdata=0x%02h -> rdata=0x%02h",
               we_k, a, d, obs_rsp_rdata);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);

    // Randomized traffic against the model on both DUTs.
    pool[0] = 8'h00; pool[1] = 8'h10; pool[2] = 8'h20; pool[3] = 8'h7F;
    pool[4] = 8'h80; pool[5] = 8'hFE; pool[6] = 8'hFF; pool[7] = 8'h41;
    for (int n = 0; n < 40; n++) begin
      logic s_n;
      s_n = 1'($urandom);
      a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
      txn(s_n, 1'($urandom), a, 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
